// File: rtl/switch_bank_ctrl_pkg.sv
// Shared constants and sizing helpers for the DIP switch bank controller.
// Optional interrupt support is selected with the SWITCH_BANK_IRQ_EN macro.
package switch_bank_ctrl_pkg;

   localparam int BANK_W = 8;

   function automatic int status_ofs(input int num_banks);
      return num_banks / 4;
   endfunction

   function automatic int mask_ofs(input int num_banks);
      return num_banks / 4 + 1;
   endfunction

   // Counter only has to reach DEBOUNCE_CYCLES-1.
   function automatic int cnt_w(input int cycles);
      return (cycles < 2) ? 1 : $clog2(cycles);
   endfunction

endpackage

// File: rtl/switch_bank_ctrl_debounce.sv
// One 8-bit active-low switch bank: two-flop synchroniser, inversion, and a
// candidate/counter debouncer producing the accepted value and a change pulse.
module switch_debounce
   import switch_bank_ctrl_pkg::*;
#(
   parameter logic [19:0] DEBOUNCE_CYCLES = 20'd1000000
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [BANK_W-1:0] pins,
   output logic [BANK_W-1:0] stable,
   output logic              change
);

   localparam int CNT_W = cnt_w(int'(DEBOUNCE_CYCLES));
   localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE_CYCLES - 20'd1);

   logic [BANK_W-1:0] sync1, sync2, cand, stable_q;
   logic [BANK_W-1:0] sync_val;
   logic [CNT_W-1:0]  cnt;

   assign sync_val = ~sync2;

   // Combinational so the status flag sets on the same edge as stable.
   assign change = (sync_val == cand) && (cand != stable_q) && (cnt == CNT_TC);
   assign stable = stable_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1    <= '0;
         sync2    <= '0;
         cand     <= '0;
         stable_q <= '0;
         cnt      <= '0;
      end else begin
         sync1 <= pins;
         sync2 <= sync1;
         if (sync_val != cand) begin
            cand <= sync_val;
            cnt  <= '0;
         end else if (cand != stable_q) begin
            if (cnt == CNT_TC) begin
               stable_q <= cand;
               cnt      <= '0;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end else begin
            cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/switch_bank_ctrl.sv
// Memory-mapped reader for NUM_BANKS debounced DIP switch banks with W1C change
// status; SWITCH_BANK_IRQ_EN adds the MASK register and the registered irq.
module switch_bank_ctrl
   import switch_bank_ctrl_pkg::*;
#(
   parameter int          NUM_BANKS       = 8,
   parameter logic [19:0] DEBOUNCE_CYCLES = 20'd1000000,
   parameter int          ADDR_WIDTH      = 4
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic [NUM_BANKS*BANK_W-1:0] dip_switch,
   input  logic [ADDR_WIDTH-1:0]       addr,
   input  logic                        we,
   input  logic [31:0]                 wdata,
   output logic [31:0]                 rdata,
   output logic                        irq
);

   localparam int NUM_WORDS  = NUM_BANKS / 4;
   localparam int STATUS_OFS = status_ofs(NUM_BANKS);
   localparam int MASK_OFS   = mask_ofs(NUM_BANKS);
   localparam logic [ADDR_WIDTH-1:0] STATUS_ADDR = ADDR_WIDTH'(STATUS_OFS);
   localparam logic [ADDR_WIDTH-1:0] MASK_ADDR   = ADDR_WIDTH'(MASK_OFS);

   logic [NUM_BANKS*BANK_W-1:0] stable_all;
   logic [NUM_BANKS-1:0]        change_vec;
   logic [NUM_BANKS-1:0]        status;
   logic [NUM_BANKS-1:0]        status_clr;
   logic                        unused_wdata;

   assign unused_wdata = ^wdata;

   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
         .clk     (clk),
         .reset_n (reset_n),
         .pins    (dip_switch[b*BANK_W +: BANK_W]),
         .stable  (stable_all[b*BANK_W +: BANK_W]),
         .change  (change_vec[b])
      );
   end

   assign status_clr = (we && addr == STATUS_ADDR) ? wdata[NUM_BANKS-1:0] : '0;

   // A change pulse wins over a simultaneous write-1-to-clear.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) status <= '0;
      else          status <= (status & ~status_clr) | change_vec;
   end

`ifdef SWITCH_BANK_IRQ_EN
   logic [NUM_BANKS-1:0] mask;
   logic                 irq_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mask  <= '0;
         irq_q <= 1'b0;
      end else begin
         if (we && addr == MASK_ADDR) mask <= wdata[NUM_BANKS-1:0];
         irq_q <= |(status & mask);
      end
   end

   assign irq = irq_q;
`else
   assign irq = 1'b0;
`endif

   always_comb begin
      rdata = '0;
      for (int w = 0; w < NUM_WORDS; w++) begin
         if (addr == ADDR_WIDTH'(w)) rdata = stable_all[w*32 +: 32];
      end
      if (addr == STATUS_ADDR) rdata[NUM_BANKS-1:0] = status;
`ifdef SWITCH_BANK_IRQ_EN
      if (addr == MASK_ADDR) rdata[NUM_BANKS-1:0] = mask;
`endif
   end

endmodule

// File: tb/tb_switch_bank_ctrl.sv
// Directed bench for switch_bank_ctrl with NUM_BANKS=8, DEBOUNCE_CYCLES=4.
// Expects the MASK/irq behaviour only when SWITCH_BANK_IRQ_EN is defined.
module tb_switch_bank_ctrl;

   localparam logic [3:0] W0 = 4'd0;
   localparam logic [3:0] W1 = 4'd1;
   localparam logic [3:0] STATUS_A = 4'd2;
   localparam logic [3:0] MASK_A = 4'd3;
`ifdef SWITCH_BANK_IRQ_EN
   localparam logic IRQ_ON = 1'b1;
`else
   localparam logic IRQ_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset_n;
   logic [63:0] dip;
   logic [3:0]  addr;
   logic        we;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        irq;
   int          total = 0;
   int          bad = 0;

   switch_bank_ctrl #(
      .NUM_BANKS(8), .DEBOUNCE_CYCLES(20'd4), .ADDR_WIDTH(4)
   ) dut (
      .clk(clk), .reset_n(reset_n), .dip_switch(dip), .addr(addr),
      .we(we), .wdata(wdata), .rdata(rdata), .irq(irq)
   );

   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [3:0] a, output logic [31:0] d);
      addr = a;
      #1;
      d = rdata;
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] d);
      addr = a; wdata = d; we = 1'b1;
      @(posedge clk);
      #1;
      we = 1'b0; wdata = '0;
   endtask

   task automatic test_reset;
      logic [31:0] d;
      reset_n = 1'b0; dip = '1; addr = '0; we = 1'b0; wdata = '0;
      step(3);
      reset_n = 1'b1;
      step(6);
      rd(W0, d); total++;
      if (d !== 32'h0) begin bad++; $display("FAIL reset_word0 got=%h exp=%h", d, 32'h0); end
      rd(W1, d); total++;
      if (d !== 32'h0) begin bad++; $display("FAIL reset_word1 got=%h exp=%h", d, 32'h0); end
      rd(STATUS_A, d); total++;
      if (d !== 32'h0) begin bad++; $display("FAIL reset_status got=%h exp=%h", d, 32'h0); end
      total++;
      if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", irq); end
   endtask

   task automatic test_debounce_latency;
      logic [31:0] d;
      dip[7:0] = 8'hFE;
      step(6);
      rd(W0, d); total++;
      if (d !== 32'h0) begin bad++; $display("FAIL lat_early got=%h exp=%h", d, 32'h0); end
      step(1);
      rd(W0, d); total++;
      if (d !== 32'h1) begin bad++; $display("FAIL lat_word0 got=%h exp=%h", d, 32'h1); end
      rd(STATUS_A, d); total++;
      if (d !== 32'h1) begin bad++; $display("FAIL lat_status got=%h exp=%h", d, 32'h1); end
      wr(STATUS_A, 32'h1);
      rd(STATUS_A, d); total++;
      if (d !== 32'h0) begin bad++; $display("FAIL w1c_status got=%h exp=%h", d, 32'h0); end
   endtask

   task automatic test_glitch;
      logic [31:0] d;
      dip[47:40] = 8'h00;
      step(3);
      dip[47:40] = 8'hFF;
      step(12);
      rd(W1, d); total++;
      if (d !== 32'h0) begin bad++; $display("FAIL glitch_word1 got=%h exp=%h", d, 32'h0); end
      rd(STATUS_A, d); total++;
      if (d !== 32'h0) begin bad++; $display("FAIL glitch_status got=%h exp=%h", d, 32'h0); end
   endtask

   task automatic test_irq;
      logic [31:0] d;
      wr(MASK_A, 32'h4);
      rd(MASK_A, d); total++;
      if (d !== (IRQ_ON ? 32'h4 : 32'h0)) begin bad++; $display("FAIL mask_read got=%h exp=%h", d, IRQ_ON ? 32'h4 : 32'h0); end
      dip[23:16] = 8'h7F;
      step(7);
      rd(STATUS_A, d); total++;
      if (d !== 32'h4) begin bad++; $display("FAIL irq_status got=%h exp=%h", d, 32'h4); end
      rd(W0, d); total++;
      if (d !== 32'h0080_0001) begin bad++; $display("FAIL irq_word0 got=%h exp=%h", d, 32'h0080_0001); end
      total++;
      if (irq !== 1'b0) begin bad++; $display("FAIL irq_early got=%b exp=0", irq); end
      step(1);
      total++;
      if (irq !== IRQ_ON) begin bad++; $display("FAIL irq_rise got=%b exp=%b", irq, IRQ_ON); end
      wr(STATUS_A, 32'h4);
      rd(STATUS_A, d); total++;
      if (d !== 32'h0) begin bad++; $display("FAIL irq_clr_status got=%h exp=%h", d, 32'h0); end
      total++;
      if (irq !== IRQ_ON) begin bad++; $display("FAIL irq_hold got=%b exp=%b", irq, IRQ_ON); end
      step(1);
      total++;
      if (irq !== 1'b0) begin bad++; $display("FAIL irq_drop got=%b exp=0", irq); end
   endtask

   task automatic test_set_wins;
      logic [31:0] d;
      dip[31:24] = 8'hFE;
      step(6);
      wr(STATUS_A, 32'h8);
      rd(STATUS_A, d); total++;
      if (d !== 32'h8) begin bad++; $display("FAIL set_wins_status got=%h exp=%h", d, 32'h8); end
      rd(W0, d); total++;
      if (d !== 32'h0180_0001) begin bad++; $display("FAIL set_wins_word0 got=%h exp=%h", d, 32'h0180_0001); end
      step(1);
      total++;
      if (irq !== 1'b0) begin bad++; $display("FAIL unmasked_irq got=%b exp=0", irq); end
      wr(STATUS_A, 32'h8);
      rd(STATUS_A, d); total++;
      if (d !== 32'h0) begin bad++; $display("FAIL set_wins_clear got=%h exp=%h", d, 32'h0); end
   endtask

   task automatic test_reset_mid_debounce;
      logic [31:0] d;
      dip = '1;
      step(10);
      wr(STATUS_A, 32'hFF);
      rd(STATUS_A, d); total++;
      if (d !== 32'h0) begin bad++; $display("FAIL mid_pre_status got=%h exp=%h", d, 32'h0); end
      dip[15:8] = 8'hFE;
      step(5);
      reset_n = 1'b0;
      step(1);
      rd(W0, d); total++;
      if (d !== 32'h0) begin bad++; $display("FAIL mid_rst_word0 got=%h exp=%h", d, 32'h0); end
      rd(MASK_A, d); total++;
      if (d !== 32'h0) begin bad++; $display("FAIL mid_rst_mask got=%h exp=%h", d, 32'h0); end
      total++;
      if (irq !== 1'b0) begin bad++; $display("FAIL mid_rst_irq got=%b exp=0", irq); end
      reset_n = 1'b1;
      step(6);
      rd(W0, d); total++;
      if (d !== 32'h0) begin bad++; $display("FAIL mid_early_word0 got=%h exp=%h", d, 32'h0); end
      rd(STATUS_A, d); total++;
      if (d !== 32'h0) begin bad++; $display("FAIL mid_early_status got=%h exp=%h", d, 32'h0); end
      step(1);
      rd(W0, d); total++;
      if (d !== 32'h0000_0100) begin bad++; $display("FAIL mid_word0 got=%h exp=%h", d, 32'h0000_0100); end
      rd(STATUS_A, d); total++;
      if (d !== 32'h2) begin bad++; $display("FAIL mid_status got=%h exp=%h", d, 32'h2); end
      wr(STATUS_A, 32'h2);
      step(10);
      rd(STATUS_A, d); total++;
      if (d !== 32'h0) begin bad++; $display("FAIL mid_single_event got=%h exp=%h", d, 32'h0); end
   endtask

   initial begin
      test_reset();
      test_debounce_latency();
      test_glitch();
      test_irq();
      test_set_wins();
      test_reset_mid_debounce();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
